multicycle_decoder: RTL and testbench
=====================================

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Op, input, 2 bits: instruction bits [27:26]; 00 data-processing, 01 memory, 10 branch.
REQ-004 SHALL have port Funct, input, 6 bits: instruction bits [25:20]; bit5 = I, bits4:1 = cmd, bit0 = S for DP or L for memory.
REQ-005 SHALL have port Rd, input, 4 bits: destination register number.
REQ-006 SHALL have ports PCS, RegW, MemW, NoWrite (outputs, 1 bit each) and FlagW (output, 2 bits), all feeding conditional_logic.
REQ-007 SHALL have ports IRWrite, NextPC, AdrSrc, ALUSrcA (outputs, 1 bit each): datapath enables and selects.
REQ-008 SHALL have ports ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc (outputs, 2 bits each).

Function
REQ-009 SHALL use an FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-010 SHALL use these transitions: FETCH->DECODE. DECODE->MEMADR (Op=01), EXECUTER (Op=00, Funct[5]=0), EXECUTEI (Op=00, Funct[5]=1), BRANCH (Op=10), FETCH (Op=11).
REQ-011 SHALL use these transitions: MEMADR->MEMREAD (Funct[0]=1) or MEMWRITE (Funct[0]=0); MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-012 SHALL drive outputs combinationally from the current state (Moore); an output not listed for a state is 0.
REQ-013 FETCH SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1, ALUOp=0.
REQ-014 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
REQ-015 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0.
REQ-016 MEMREAD SHALL drive ResultSrc=00, AdrSrc=1.
REQ-017 MEMWB SHALL drive ResultSrc=01, internal RegW=1.
REQ-018 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1, MemW=1.
REQ-019 EXECUTER SHALL drive ALUSrcA=0, ALUSrcB=00, ALUOp=1.
REQ-020 EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=1.
REQ-021 ALUWB SHALL drive ResultSrc=00, internal RegW=1.
REQ-022 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
REQ-023 SHALL compute PCS = ((Rd==4'b1111) & RegW) | Branch.
REQ-024 With ALUOp=0, SHALL output ALUControl=00, FlagW=00, NoWrite=0.
REQ-025 With ALUOp=1, SHALL decode cmd as ADD 0100->00, SUB 0010->01, AND 0000->10, ORR 1100->11, CMP 1010->01 with NoWrite=1; any other cmd -> ALUControl=00, NoWrite=0.
REQ-026 With ALUOp=1 and S=1, SHALL set FlagW[1]=1 and FlagW[0]=1 only when cmd is ADD, SUB or CMP; with S=0, FlagW=00.
REQ-027 SHALL output ImmSrc=Op in every state.
REQ-028 SHALL output RegSrc[0]=(Op==10) and RegSrc[1]=(Op==01) in every state.
REQ-029 SHALL give latencies FETCH-to-FETCH of: LDR 5 cycles; STR, DP-reg and DP-imm 4 cycles; B 3 cycles; Op=11 2 cycles.

Reset
REQ-030 Reset=0 SHALL force state to FETCH immediately, independent of clk, aborting any in-progress instruction.
REQ-031 While Reset=0, outputs SHALL equal the FETCH values: IRWrite=1, NextPC=1, RegW=MemW=PCS=0.
REQ-032 On the first rising edge after Reset deasserts, state SHALL move to DECODE.

Verification
REQ-033 ADD R1 (Op=00, Funct=001000, Rd=0001): states FETCH,DECODE,EXECUTER,ALUWB; ALUControl=00 in EXECUTER; RegW=1, PCS=0 in ALUWB.
REQ-034 LDR (Op=01, Funct=011001): 5-cycle path; AdrSrc=1 in MEMREAD; ResultSrc=01, RegW=1 in MEMWB; MemW=0 throughout.
REQ-035 STR (Op=01, Funct=011000): MemW=1 only in MEMWRITE, then FETCH.
REQ-036 B (Op=10): 3-cycle path; PCS=1, ALUSrcB=01 in BRANCH.
REQ-037 CMP imm (Op=00, Funct=110101): EXECUTEI drives ALUControl=01, FlagW=11, NoWrite=1; SUB to Rd=1111 drives PCS=1 in ALUWB.
REQ-038 Reset pulled low in MEMREAD mid-cycle: state becomes FETCH asynchronously, AdrSrc=0, IRWrite=1, RegW=0.

Source files
------------

// File: rtl/multicycle_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_decoder
//
// Control unit for a multicycle ARM-subset datapath. A Moore FSM steps each
// instruction through fetch, decode and the execute/memory/writeback phases
// that its class needs. The datapath selects follow the current state only.
// The ALU decoder refines ALUControl, FlagW and NoWrite from Funct whenever
// the state asks for an ALU operation.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   Reset      : asynchronous active-low reset; forces the FETCH state
//   Op[1:0]    : instruction class (00 DP, 01 memory, 10 branch, 11 none)
//   Funct[5:0] : {I, cmd[3:0], S/L}
//   Rd[3:0]    : destination register number (Rd=15 means a PC write)
//   PCS, RegW, MemW, NoWrite, FlagW[1:0] : to conditional logic
//   IRWrite, NextPC, AdrSrc, ALUSrcA     : datapath enables and selects
//   ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc [1:0] : datapath selects
// -----------------------------------------------------------------------------
module multicycle_decoder (
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       alu_op;
  logic       branch;
  logic [3:0] cmd;

  assign cmd = Funct[4:1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;   // undefined class: drop it and refetch
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;  // L bit
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;      // MEMWB, MEMWRITE, ALUWB, BRANCH
    endcase
  end

  // Reset aborts whatever instruction is in flight, without waiting for clk.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs of the main FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        alu_op = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decoder: only active while the FSM requests a data-processing op
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUControl = 2'b00;
    NoWrite    = 1'b0;
    FlagW      = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;      // ADD
        4'b0010: ALUControl = 2'b01;      // SUB
        4'b0000: ALUControl = 2'b10;      // AND
        4'b1100: ALUControl = 2'b11;      // ORR
        4'b1010: begin                    // CMP: subtract, flags only
          ALUControl = 2'b01;
          NoWrite    = 1'b1;
        end
        default: ALUControl = 2'b00;
      endcase
      // NZ always follow S; CV only for arithmetic commands
      if (Funct[0]) begin
        FlagW[1] = 1'b1;
        FlagW[0] = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
      end
    end
  end

  // A register write to R15 is a PC write
  assign PCS = ((Rd == 4'b1111) & RegW) | branch;

  assign ImmSrc    = Op;
  assign RegSrc[0] = (Op == 2'b10);
  assign RegSrc[1] = (Op == 2'b01);

endmodule

// File: tb/tb_multicycle_decoder.sv
module tb_multicycle_decoder;

  logic       clk;
  logic       Reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

  multicycle_decoder dut (
    .clk        (clk),
    .Reset      (Reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .FlagW      (FlagW),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Phase identifiers of the reference model (named after the spec's phases)
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                 P_ALUWB = 8, P_BRANCH = 9;

  function automatic logic [19:0] observed();
    return {PCS, RegW, MemW, NoWrite, FlagW, IRWrite, NextPC, AdrSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
  endfunction

  // Reference: per-phase output table from the spec, plus ALU decode rules.
  function automatic logic [19:0] ref_outputs(int ph, logic [1:0] op,
                                              logic [5:0] f, logic [3:0] rd);
    logic irw, npc, adr, srca, regw, memw, aluop, br, nw, pcs;
    logic [1:0] srcb, res, ctl, flg, rs;
    int c;
    irw = 0; npc = 0; adr = 0; srca = 0; regw = 0; memw = 0; aluop = 0;
    br = 0; nw = 0; srcb = 0; res = 0; ctl = 0; flg = 0;
    if (ph == P_FETCH)    begin srca = 1; srcb = 2; res = 2; irw = 1; npc = 1; end
    if (ph == P_DECODE)   begin srca = 1; srcb = 2; res = 2; end
    if (ph == P_MEMADR)   begin srcb = 1; end
    if (ph == P_MEMREAD)  begin adr = 1; end
    if (ph == P_MEMWB)    begin res = 1; regw = 1; end
    if (ph == P_MEMWRITE) begin adr = 1; memw = 1; end
    if (ph == P_EXECR)    begin aluop = 1; end
    if (ph == P_EXECI)    begin srcb = 1; aluop = 1; end
    if (ph == P_ALUWB)    begin regw = 1; end
    if (ph == P_BRANCH)   begin srcb = 1; res = 2; br = 1; end
    if (aluop) begin
      c = int'(f[4:1]);
      if (c == 4)       ctl = 2'd0;
      else if (c == 2)  ctl = 2'd1;
      else if (c == 0)  ctl = 2'd2;
      else if (c == 12) ctl = 2'd3;
      else if (c == 10) begin ctl = 2'd1; nw = 1; end
      if (f[0]) flg = {1'b1, (c == 4 || c == 2 || c == 10)};
    end
    pcs = (rd == 15 && regw) || br;
    rs  = {op == 2'b01, op == 2'b10};
    return {pcs, regw, memw, nw, flg, irw, npc, adr, srca, srcb, res, ctl, op, rs};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Phase sequence for one instruction, derived from its class
  task automatic build_seq(input logic [1:0] op, input logic [5:0] f, output int seq[$]);
    seq = {};
    seq.push_back(P_FETCH);
    seq.push_back(P_DECODE);
    if (op == 2'b00) begin
      seq.push_back(f[5] ? P_EXECI : P_EXECR);
      seq.push_back(P_ALUWB);
    end else if (op == 2'b01) begin
      seq.push_back(P_MEMADR);
      if (f[0]) begin seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
      else seq.push_back(P_MEMWRITE);
    end else if (op == 2'b10) begin
      seq.push_back(P_BRANCH);
    end
  endtask

  // Entered while the DUT sits in FETCH, away from the clock edge.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd);
    int seq[$];
    Op = op; Funct = f; Rd = rd;
    build_seq(op, f, seq);
    #1;
    foreach (seq[i]) begin
      check($sformatf("%s_c%0d", name, i), 32'(observed()), 32'(ref_outputs(seq[i], op, f, rd)));
      @(posedge clk); #1;
    end
    // latency: the cycle after the last phase must be a fresh fetch
    check($sformatf("%s_lat", name), 32'(IRWrite), 32'd1);
    $display("instr %s op=%b funct=%b rd=%0d cycles=%0d", name, op, f, rd, seq.size());
  endtask

  initial begin
    Reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #12;
    check("reset_state", 32'(observed()), 32'(ref_outputs(P_FETCH, 2'b00, 6'd0, 4'd0)));
    @(posedge clk); #1;
    check("reset_hold", 32'(observed()), 32'(ref_outputs(P_FETCH, 2'b00, 6'd0, 4'd0)));
    @(negedge clk);
    Reset = 1'b1;

    // Directed instructions
    run_instr("add_r1",  2'b00, 6'b001000, 4'd1);
    run_instr("ldr",     2'b01, 6'b011001, 4'd2);
    run_instr("str",     2'b01, 6'b011000, 4'd3);
    run_instr("b",       2'b10, 6'b000000, 4'd0);
    run_instr("cmp_imm", 2'b00, 6'b110101, 4'd4);
    run_instr("sub_pc",  2'b00, 6'b000100, 4'd15);
    run_instr("ldr_pc",  2'b01, 6'b000001, 4'd15);
    run_instr("orr_s",   2'b00, 6'b011001, 4'd5);
    run_instr("and_s",   2'b00, 6'b100001, 4'd6);
    run_instr("op11",    2'b11, 6'b111111, 4'd15);

    // Randomised instructions
    for (int k = 0; k < 80; k++) begin
      run_instr($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)),
                6'($urandom), 4'($urandom));
    end

    // Asynchronous reset in the middle of a load
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd7;
    @(posedge clk); #1;   // DECODE
    @(posedge clk); #1;   // MEMADR
    @(posedge clk); #1;   // MEMREAD
    check("rst_pre_memread", 32'(observed()), 32'(ref_outputs(P_MEMREAD, Op, Funct, Rd)));
    #2 Reset = 1'b0;
    #1;
    check("rst_async", 32'(observed()), 32'(ref_outputs(P_FETCH, Op, Funct, Rd)));
    check("rst_adrsrc", 32'(AdrSrc), 32'd0);
    check("rst_regw", 32'(RegW), 32'd0);
    @(posedge clk); #1;
    check("rst_low_edge", 32'(observed()), 32'(ref_outputs(P_FETCH, Op, Funct, Rd)));
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); #1;
    check("rst_release", 32'(observed()), 32'(ref_outputs(P_DECODE, Op, Funct, Rd)));
    $display("instr reset_mid_ldr op=%b funct=%b rd=%0d", Op, Funct, Rd);

    // Bring the FSM back to FETCH and run one more instruction
    #1 Reset = 1'b0;
    #1 Reset = 1'b1;
    run_instr("post_rst", 2'b00, 6'b000101, 4'd9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
